axi_burst_scheduler: RTL and testbench
======================================

AXI_BURST_SCHEDULER -- requirements
Module: axi_burst_scheduler

Interface
REQ-001 Parameter ADDR_W, default 32, address width in bits.
REQ-002 Parameter DATA_W, default 64, data width in bits; the byte count per beat is BPB = DATA_W/8, which is a power of two from 1 to 128.
REQ-003 aclk  in  1  clock; reset aresetn, synchronous, active-low; clock aclk.
REQ-004 aresetn  in  1  synchronous active-low reset.
REQ-005 req_valid  in  1  transfer request valid.
REQ-006 req_ready  out  1  scheduler can accept a request.
REQ-007 req_w_r  in  1  0 = write, 1 = read.
REQ-008 req_addr  in  ADDR_W  start byte address; the low log2(BPB) bits are forced to zero.
REQ-009 req_beats  in  16  total beats to transfer (0..65535).
REQ-010 done  out  1  one-cycle pulse when the transfer completes.
REQ-011 done_status  out  2  response code for the transfer: 00 OKAY, or the first response with bit 1 set (SLVERR/DECERR).
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 mst_start  out  1  burst start strobe to the burst master.
REQ-014 mst_w_r  out  1  burst direction.
REQ-015 mst_addr  out  ADDR_W  burst start address.
REQ-016 mst_len  out  8  burst length minus one.
REQ-017 mst_free  in  1  burst master can accept a start.
REQ-018 mst_burst_done  in  1  one-cycle pulse per completed burst (B handshake for writes, RLAST for reads).
REQ-019 mst_burst_status  in  2  BRESP or last RRESP, valid with mst_burst_done.

Function
REQ-020 FSM states: IDLE, CALC, ISSUE, WAIT, DONE.
REQ-021 req_ready = (state == IDLE); a request is accepted on req_valid & req_ready and latches direction, aligned address and remaining beats.
REQ-022 IDLE -> CALC on accept when req_beats != 0; IDLE -> DONE on accept when req_beats == 0 (no burst, done_status 00).
REQ-023 CALC (1 cycle): beats_4k = (4096 - cur_addr[11:0]) / BPB; burst_beats = min(remaining, 256, beats_4k); mst_len = burst_beats - 1; CALC -> ISSUE.
REQ-024 Width rules: remaining is 17 bits internally; beats_4k is 13 bits; burst_beats is 9 bits; no truncation before the min.
REQ-025 ISSUE: mst_w_r, mst_addr and mst_len are held stable; mst_start is high for exactly one cycle, in the first ISSUE cycle with mst_free = 1; ISSUE -> WAIT after that cycle.
REQ-026 mst_addr, mst_len and mst_w_r are held constant from CALC exit until WAIT exit; mst_start is 0 in every other state.
REQ-027 WAIT: on mst_burst_done, remaining -= burst_beats and cur_addr += burst_beats*BPB (modulo 2^ADDR_W).
REQ-028 Status capture: if mst_burst_status[1] = 1 and no error is yet captured, latch the status into done_status.
REQ-029 Exit from WAIT on mst_burst_done: to DONE if the new remaining = 0 or an error is captured, else to CALC; the remaining bursts are abandoned after an error.
REQ-030 An mst_burst_done pulse outside WAIT is ignored.
REQ-031 DONE (1 cycle): done = 1 and done_status is valid; DONE -> IDLE; done_status holds until the next accept clears it to 00.
REQ-032 Only one burst is outstanding at a time; no mst_start is issued while in WAIT.
REQ-033 Latency: accept to first mst_start is 2 cycles when mst_free = 1; burst done to next mst_start is 2 cycles.

Reset
REQ-034 While aresetn = 0, at the next edge: state = IDLE, req_ready = 1 after reset, done = 0, done_status = 00, busy = 0, mst_start = 0, mst_addr = 0, mst_len = 0, mst_w_r = 0, and all internal counters = 0.
REQ-035 Reset asserted mid-transfer abandons the transfer: no done pulse and no further mst_start.

Structure
REQ-036 The shared package axi_burst_pkg holds the 4 KB boundary constant (4096), the maximum burst beat count (256), the FSM state encoding and the response codes (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11).
REQ-037 One sub-module, axi_burst_len_calc, is natural: combinational, computing burst_beats and mst_len from cur_addr and remaining; the FSM and its registers stay in the top level.

Verification (DATA_W=64, BPB=8; mst_free=1 and every burst completes with status 00 unless stated)
REQ-038 Write, addr 0x0000_0000, beats 1 -> one mst_start with addr 0x0, len 0; done with status 00.
REQ-039 addr 0x0000_0FF0, beats 10 -> bursts (0xFF0, len 1) then (0x1000, len 7); done once.
REQ-040 Read, addr 0x0, beats 600 -> bursts (0x0, len 255), (0x800, len 255), (0x1000, len 87); done.
REQ-041 Same as REQ-040 with the second burst status 10 -> no third burst; done with done_status 10.
REQ-042 beats 0 -> no mst_start; done 2 cycles after accept, status 00; with mst_free held 0 for 5 cycles in ISSUE, mst_start waits and then fires once.
REQ-043 aresetn low during WAIT -> all outputs at reset values; a later mst_burst_done produces no done pulse.

Source files
------------

// File: rtl/axi_burst_pkg.sv
// Shared constants, FSM encoding and AXI response codes for the burst scheduler.
package axi_burst_pkg;

    localparam logic [12:0] BOUNDARY_4K     = 13'd4096;
    localparam logic [8:0]  MAX_BURST_BEATS = 9'd256;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // SLVERR and DECERR both carry bit 1; EXOKAY does not.
    function automatic logic is_error(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_burst_scheduler_if.sv
// Link between the scheduler (master modport) and the AXI burst engine (slave modport).
interface axi_burst_scheduler_if #(
    parameter int ADDR_W = 32
);
    logic              mst_start;
    logic              mst_w_r;
    logic [ADDR_W-1:0] mst_addr;
    logic [7:0]        mst_len;
    logic              mst_free;
    logic              mst_burst_done;
    logic [1:0]        mst_burst_status;

    modport master (
        output mst_start, mst_w_r, mst_addr, mst_len,
        input  mst_free, mst_burst_done, mst_burst_status
    );

    modport slave (
        input  mst_start, mst_w_r, mst_addr, mst_len,
        output mst_free, mst_burst_done, mst_burst_status
    );
endinterface

// File: rtl/axi_burst_len_calc.sv
// Next burst size: the smallest of remaining beats, 256 and beats left in the 4 KB page.
module axi_burst_len_calc
    import axi_burst_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [11:0] page_off,
    input  logic [16:0] remaining,
    output logic [8:0]  burst_beats,
    output logic [7:0]  mst_len
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic [12:0] beats_4k_s;
    logic [16:0] min_s;

    // Full-width min so no operand is truncated before comparison.
    always_comb begin
        beats_4k_s = (BOUNDARY_4K - {1'b0, page_off}) >> OFF_W;
        min_s      = ({4'd0, beats_4k_s} < remaining) ? {4'd0, beats_4k_s} : remaining;
        if ({8'd0, MAX_BURST_BEATS} < min_s) begin
            burst_beats = MAX_BURST_BEATS;
        end else begin
            burst_beats = min_s[8:0];
        end
        mst_len = 8'(burst_beats - 9'd1);
    end
endmodule

// File: rtl/axi_burst_scheduler.sv
// Splits a beat-count transfer into AXI bursts that respect 256-beat and 4 KB limits,
// issuing one burst at a time and reporting the first error response.
module axi_burst_scheduler
    import axi_burst_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_w_r,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [15:0]           req_beats,
    output logic                  done,
    output logic [1:0]            done_status,
    output logic                  busy,
    axi_burst_scheduler_if.master mst
);
    localparam int BPB   = DATA_W / 8;
    localparam int OFF_W = $clog2(BPB);

    state_e            state_q, state_d;
    logic              w_r_q, w_r_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [16:0]       remaining_q, remaining_d;
    logic [8:0]        burst_beats_q, burst_beats_d;
    logic [ADDR_W-1:0] mst_addr_q, mst_addr_d;
    logic [7:0]        mst_len_q, mst_len_d;
    logic              done_q, done_d;
    logic [1:0]        done_status_q, done_status_d;

    logic [8:0]        calc_beats_s;
    logic [7:0]        calc_len_s;
    logic [ADDR_W-1:0] step_s;

    axi_burst_len_calc #(.DATA_W(DATA_W)) u_len_calc (
        .page_off    (cur_addr_q[11:0]),
        .remaining   (remaining_q),
        .burst_beats (calc_beats_s),
        .mst_len     (calc_len_s)
    );

    assign step_s = ADDR_W'(burst_beats_q) << OFF_W;

    // Next-state and datapath updates for the scheduler FSM.
    always_comb begin
        state_d       = state_q;
        w_r_d         = w_r_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        burst_beats_d = burst_beats_q;
        mst_addr_d    = mst_addr_q;
        mst_len_d     = mst_len_q;
        done_status_d = done_status_q;
        done_d        = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    w_r_d         = req_w_r;
                    cur_addr_d    = req_addr & ~ADDR_W'(BPB - 1);
                    remaining_d   = {1'b0, req_beats};
                    done_status_d = RESP_OKAY;
                    state_d       = (req_beats == 16'd0) ? ST_DONE : ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                mst_addr_d    = cur_addr_q;
                mst_len_d     = calc_len_s;
                burst_beats_d = calc_beats_s;
                state_d       = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (mst.mst_free) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mst.mst_burst_done) begin
                    remaining_d = remaining_q - {8'd0, burst_beats_q};
                    cur_addr_d  = cur_addr_q + step_s;
                    // Only the first error is kept; later responses cannot overwrite it.
                    if (is_error(mst.mst_burst_status) && !is_error(done_status_q)) begin
                        done_status_d = mst.mst_burst_status;
                    end else begin
                        done_status_d = done_status_q;
                    end
                    if ((remaining_d == 17'd0) || is_error(done_status_d)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            w_r_q         <= 1'b0;
            cur_addr_q    <= '0;
            remaining_q   <= 17'd0;
            burst_beats_q <= 9'd0;
            mst_addr_q    <= '0;
            mst_len_q     <= 8'd0;
            done_q        <= 1'b0;
            done_status_q <= RESP_OKAY;
        end else begin
            state_q       <= state_d;
            w_r_q         <= w_r_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            burst_beats_q <= burst_beats_d;
            mst_addr_q    <= mst_addr_d;
            mst_len_q     <= mst_len_d;
            done_q        <= done_d;
            done_status_q <= done_status_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign done_status  = done_status_q;
    // Start must react to mst_free in the same ISSUE cycle, so it is decoded from state.
    assign mst.mst_start = (state_q == ST_ISSUE) && mst.mst_free;
    assign mst.mst_w_r   = w_r_q;
    assign mst.mst_addr  = mst_addr_q;
    assign mst.mst_len   = mst_len_q;
endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Scoreboard bench: a page/length reference model queues expected bursts and completion
// status, and an independent monitor compares them against what the scheduler emits.
module tb_axi_burst_scheduler;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_w_r;
    logic [31:0] req_addr;
    logic [15:0] req_beats;
    logic        done;
    logic [1:0]  done_status;
    logic        busy;

    always #5 aclk = ~aclk;

    axi_burst_scheduler_if #(.ADDR_W(32)) mst_if ();

    axi_burst_scheduler #(.ADDR_W(32), .DATA_W(64)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_w_r     (req_w_r),
        .req_addr    (req_addr),
        .req_beats   (req_beats),
        .done        (done),
        .done_status (done_status),
        .busy        (busy),
        .mst         (mst_if)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        w_r;
    } burst_t;

    burst_t     exp_burst_q[$];
    logic [1:0] resp_q[$];
    logic [1:0] exp_done_q[$];

    int     checks    = 0;
    int     errors    = 0;
    int     done_cnt  = 0;
    int     start_cnt = 0;
    int     free_mode = 0;
    int     kick_cnt  = 0;
    int     kick_seen = 0;
    bit     resp_en   = 1'b1;
    burst_t mon_e;
    logic [1:0] mon_st;
    logic [1:0] rsp_s;
    logic [1:0] tmp_st;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the transfer in page/256-beat chunks, stop after first error.
    task automatic push_model(input logic w_r, input logic [31:0] addr, input logic [15:0] beats,
                              input int err_at, input bit rnd, output logic [1:0] st);
        logic [31:0] a;
        int rem, room, n, i;
        logic [1:0] s;
        a   = addr & 32'hFFFF_FFF8;
        rem = int'(beats);
        i   = 0;
        st  = 2'b00;
        while (rem > 0) begin
            room = (4096 - int'(a[11:0])) / 8;
            n = rem;
            if (n > 256)  n = 256;
            if (n > room) n = room;
            if (i == err_at) s = 2'b10;
            else if (rnd && $urandom_range(0, 11) == 0) s = 2'($urandom_range(1, 3));
            else s = 2'b00;
            exp_burst_q.push_back('{a, 8'(n - 1), w_r});
            resp_q.push_back(s);
            if (s[1]) begin
                st = s;
                break;
            end
            rem -= n;
            a = a + 32'(n * 8);
            i++;
        end
        exp_done_q.push_back(st);
    endtask

    task automatic drive_req(input logic w_r, input logic [31:0] addr, input logic [15:0] beats);
        int k = 0;
        while (!req_ready && k < 1000) begin
            @(negedge aclk);
            k++;
        end
        chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_w_r   = w_r;
        req_addr  = addr;
        req_beats = beats;
        @(negedge aclk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_beats = 16'($urandom);
    endtask

    task automatic wait_done(input int base);
        int k = 0;
        while (done_cnt == base && k < 20000) begin
            @(negedge aclk);
            k++;
        end
        chk("done_arrived", done_cnt != base, 1);
    endtask

    task automatic run_req(input logic w_r, input logic [31:0] addr, input logic [15:0] beats,
                           input int err_at, input bit rnd, input bit lat);
        logic [1:0] st;
        int base;
        push_model(w_r, addr, beats, err_at, rnd, st);
        base = done_cnt;
        drive_req(w_r, addr, beats);
        if (lat) begin
            @(negedge aclk);
            if (beats == 16'd0) chk("zero_done_latency", done, 1);
            else chk("first_start_latency", mst_if.mst_start, 1);
        end
        wait_done(base);
        @(negedge aclk);
        @(negedge aclk);
        chk("status_hold", done_status, st);
    endtask

    // Monitor: every start and done is popped against the scoreboard queues.
    initial begin
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (mst_if.mst_start) begin
                    start_cnt++;
                    if (exp_burst_q.size() == 0) begin
                        chk("unexpected_start", 1, 0);
                    end else begin
                        mon_e = exp_burst_q.pop_front();
                        chk("burst_addr", mst_if.mst_addr, mon_e.addr);
                        chk("burst_len", mst_if.mst_len, mon_e.len);
                        chk("burst_w_r", mst_if.mst_w_r, mon_e.w_r);
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (exp_done_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        mon_st = exp_done_q.pop_front();
                        chk("done_status", done_status, mon_st);
                    end
                end
            end
        end
    end

    // Burst engine model: answers each start after a random delay with the queued response.
    initial begin
        mst_if.mst_burst_done   = 1'b0;
        mst_if.mst_burst_status = 2'b00;
        forever begin
            @(negedge aclk);
            if ((mst_if.mst_start && resp_en) || kick_cnt != kick_seen) begin
                kick_seen = kick_cnt;
                if (mst_if.mst_start && resp_en && resp_q.size() > 0) rsp_s = resp_q.pop_front();
                else rsp_s = 2'b00;
                @(posedge aclk);
                #1;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge aclk);
                    #1;
                end
                mst_if.mst_burst_done   = 1'b1;
                mst_if.mst_burst_status = rsp_s;
                @(posedge aclk);
                #1;
                mst_if.mst_burst_done   = 1'b0;
                mst_if.mst_burst_status = 2'($urandom);
            end
        end
    end

    // mst_free driver: 0 = always free, 1 = random, 2 = held busy.
    initial begin
        mst_if.mst_free = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (free_mode == 0) mst_if.mst_free = 1'b1;
            else if (free_mode == 1) mst_if.mst_free = ($urandom_range(0, 3) != 0);
            else mst_if.mst_free = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_d, base_s, k;
        aresetn   = 1'b0;
        req_valid = 1'b0;
        req_w_r   = 1'b0;
        req_addr  = 32'd0;
        req_beats = 16'd0;
        repeat (3) @(negedge aclk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_status", done_status, 0);
        chk("rst_mst_start", mst_if.mst_start, 0);
        chk("rst_mst_len", mst_if.mst_len, 0);
        aresetn = 1'b1;
        @(negedge aclk);

        free_mode = 0;
        run_req(1'b0, 32'h0000_0000, 16'd1,   -1, 1'b0, 1'b1);
        run_req(1'b0, 32'h0000_0FF0, 16'd10,  -1, 1'b0, 1'b1);
        run_req(1'b1, 32'h0000_0000, 16'd600, -1, 1'b0, 1'b1);
        run_req(1'b1, 32'h0000_0000, 16'd600,  1, 1'b0, 1'b1);
        run_req(1'b0, 32'h0000_0000, 16'd0,   -1, 1'b0, 1'b1);
        run_req(1'b1, 32'h0000_0FFF, 16'd3,   -1, 1'b0, 1'b1);

        // Burst master busy for five ISSUE cycles: start must wait, then fire once.
        free_mode = 2;
        @(negedge aclk);
        @(negedge aclk);
        push_model(1'b0, 32'h0000_0040, 16'd8, -1, 1'b0, tmp_st);
        base_d = done_cnt;
        drive_req(1'b0, 32'h0000_0040, 16'd8);
        for (int c = 2; c <= 6; c++) begin
            @(negedge aclk);
            chk("start_held_low", mst_if.mst_start, 0);
            chk("addr_stable", mst_if.mst_addr, 32'h40);
        end
        free_mode = 0;
        @(negedge aclk);
        chk("start_after_free", mst_if.mst_start, 1);
        wait_done(base_d);

        free_mode = 1;
        for (int r = 0; r < 40; r++) begin
            run_req(1'($urandom_range(0, 1)), $urandom, 16'($urandom_range(0, 1500)), -1, 1'b1, 1'b0);
        end
        run_req(1'b0, 32'hFFFF_F000, 16'hFFFF, -1, 1'b0, 1'b0);

        // Reset while a burst is outstanding.
        free_mode = 0;
        resp_en   = 1'b0;
        exp_burst_q.push_back('{32'h0000_1230, 8'd255, 1'b1});
        base_s = start_cnt;
        drive_req(1'b1, 32'h0000_1230, 16'd600);
        k = 0;
        while (start_cnt == base_s && k < 100) begin
            @(negedge aclk);
            k++;
        end
        chk("rst_test_first_start", start_cnt - base_s, 1);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_done_status", done_status, 0);
        chk("midrst_mst_start", mst_if.mst_start, 0);
        chk("midrst_mst_addr", mst_if.mst_addr, 0);
        chk("midrst_mst_len", mst_if.mst_len, 0);
        chk("midrst_mst_w_r", mst_if.mst_w_r, 0);
        aresetn = 1'b1;
        base_d = done_cnt;
        base_s = start_cnt;
        kick_cnt++;
        repeat (12) @(negedge aclk);
        chk("no_done_after_reset", done_cnt, base_d);
        chk("no_start_after_reset", start_cnt, base_s);
        resp_en = 1'b1;

        chk("burst_queue_empty", exp_burst_q.size(), 0);
        chk("done_queue_empty", exp_done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
